mem_arbiter_rr: RTL and testbench
=================================

Name: mem_arbiter_rr

Overview:
- Parametrised multi-channel memory controller; successor to the fixed three-port controller (fetcher/LSB/ROB).
- Arbitrates NUM_CH requestors round-robin onto the single byte-serial RAM/IO bus.
- Performs 1/2/4-byte reads (sign- or zero-extended) and writes, aborts flushable reads on misbranch, and throttles IO writes against UART back-pressure.

Parameters:
- NUM_CH, 3, number of requestor channels (≥2).
- FLUSH_MASK, 3'b011, bit i set: channel i reads abort on misbranch.
- IO_GAP, 2, mandatory idle cycles after any IO write before the next IO write may start.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  low: freeze all state and outputs.
- in_req_ce  in  NUM_CH  per-channel request; held until out_done.
- in_req_wr  in  NUM_CH  1 = write.
- in_req_size  in  2*NUM_CH  per channel: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes.
- in_req_signed  in  NUM_CH  sign-extend read result.
- in_req_addr  in  32*NUM_CH  byte address.
- in_req_data  in  32*NUM_CH  write data, little-endian.
- in_misbranch  in  1  flush.
- in_uart_full  in  1  UART buffer full.
- in_ram_data  in  8  RAM read byte.
- out_ram_rw  out  1  1 = write.
- out_ram_address  out  32  RAM address.
- out_ram_data  out  8  RAM write byte.
- out_done  out  NUM_CH  one-cycle completion pulse.
- out_data  out  32  read result; valid only when out_done is high.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, RR pointer = NUM_CH-1 (channel 0 wins first), IO gap counter = 0.
- States: IDLE, READ, WRITE, IO_WAIT, DONE. All outputs are registered.
- IDLE, cycle T:
  - Grant the first requesting channel, searching from pointer+1 mod NUM_CH upward; pointer := granted channel.
  - Latch addr, size, signed, data; byte count n = 1/2/4.
- Read:
  - Byte k address (addr+k, rw=0) is visible in cycle T+1+k.
  - in_ram_data for byte k is sampled in cycle T+2+k and placed in bits [8k+7:8k].
  - DONE at cycle T+n+2: out_done[ch]=1 and out_data = extended result. A 4-byte read takes 6 cycles from request to done.
- Write:
  - Byte k visible in cycle T+1+k with rw=1 and data = data[8k+7:8k].
  - DONE at T+n+1.
  - out_ram_rw returns to 0 in the cycle after the last byte.
- IO address: addr[17:16] == 2'b11.
  - IO writes with in_uart_full=1 at grant, or while the gap counter is nonzero, go to IO_WAIT. Bus holds rw=0.
  - Leave IO_WAIT in the first cycle where full=0 and gap=0; issue as a normal write.
  - After an IO write's last byte, gap counter := IO_GAP, then decrements each cycle.
  - IO reads are unthrottled.
- DONE lasts one cycle and then returns to IDLE; no grant is made in DONE. The requestor must drop in_req_ce by the cycle after out_done.
- Extension: size 0 or 1 with signed=1 sign-extends bit 7 or bit 15; otherwise zero-extends. Size 3 is treated as 4.
- Address arithmetic is 32-bit wrap-around; no alignment check.
- Misbranch (in_misbranch=1 in cycle M):
  - If the FSM is in READ on a channel with its FLUSH_MASK bit set, go to IDLE at M+1 with no out_done and out_ram_rw=0.
  - Writes, IO_WAIT writes, and reads on unflushable channels continue unaffected.
  - No new grant in cycle M. The RR pointer is kept.
- Simultaneous events:
  - Misbranch in the same cycle as DONE: out_done still fires. The requestor discards it.
  - Misbranch in the IDLE grant cycle: no grant.
- rdy=0: state, counters, and all outputs hold; in_ram_data is not sampled. Resume exactly where stalled.
- rst mid-transaction: abort immediately, no out_done, reset values next cycle.

Test Plan:
- Ch1 reads 4 bytes at 0x100 holding 0x78,0x56,0x34,0x12 -> out_done[1] at T+6, out_data=0x12345678, addresses 0x100..0x103 on T+1..T+4.
- Ch0 signed byte read of 0x80 -> 0xFFFFFF80; unsigned -> 0x00000080; signed half 0x8001 -> 0xFFFF8001.
- Ch0, ch1, ch2 request continuously after reset -> grants in order 0,1,2,0; no channel is granted twice while another waits.
- Ch0 4-byte read, misbranch at T+3 -> no out_done[0], rw=0, IDLE at T+4. Repeat with a ch2 write -> write completes and out_done[2] fires.
- Ch2 writes 0x41 to 0x30000 with uart_full=1 for 5 cycles -> rw stays 0; byte issued the first cycle full=0. A second IO write is delayed at least IO_GAP cycles.
- Write 0xDEADBEEF to 0x200, then read back 4 bytes; rdy=0 for 3 cycles mid-read -> bus frozen, result 0xDEADBEEF, done delayed exactly 3 cycles.

Source files
------------

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter of NUM_CH requestors onto one byte-serial RAM/IO bus; 1/2/4-byte reads and writes.
// Latency: read done at grant+n+2, write done at grant+n+1 (n = byte count); IO writes may wait in IO_WAIT.
// Backpressure: rdy=0 freezes everything; in_uart_full and the IO gap counter hold IO writes off the bus.
module mem_arbiter_rr #(
  parameter int                NUM_CH     = 3,
  parameter logic [NUM_CH-1:0] FLUSH_MASK = NUM_CH'(3'b011),
  parameter int                IO_GAP     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [NUM_CH-1:0]     in_req_ce,
  input  logic [NUM_CH-1:0]     in_req_wr,
  input  logic [2*NUM_CH-1:0]   in_req_size,
  input  logic [NUM_CH-1:0]     in_req_signed,
  input  logic [32*NUM_CH-1:0]  in_req_addr,
  input  logic [32*NUM_CH-1:0]  in_req_data,
  input  logic                  in_misbranch,
  input  logic                  in_uart_full,
  input  logic [7:0]            in_ram_data,
  output logic                  out_ram_rw,
  output logic [31:0]           out_ram_address,
  output logic [7:0]            out_ram_data,
  output logic [NUM_CH-1:0]     out_done,
  output logic [31:0]           out_data
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int GW = $clog2(IO_GAP + 2);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_IO_WAIT, S_DONE} state_t;

  state_t            state_q, state_n;
  logic [PW-1:0]     ptr_q, ptr_n, ch_q, ch_n, grant;
  logic              grant_vld;
  logic [31:0]       addr_q, addr_n, wdat_q, wdat_n, rbuf_q, rbuf_n, rbuf_ins;
  logic [1:0]        size_q, size_n;
  logic              sgn_q, sgn_n, io_q, io_n;
  logic [2:0]        cnt_q, cnt_n, n_cur;
  logic [GW-1:0]     gap_q, gap_n;
  logic              ram_rw_n;
  logic [31:0]       ram_addr_n, data_n;
  logic [7:0]        ram_dat_n;
  logic [NUM_CH-1:0] done_n;
  logic [1:0]        rd_k, wr_nk;
  logic [31:0]       g_addr, g_dat;
  logic [1:0]        g_size;
  logic              g_wr, g_sgn, g_io;

  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size, input logic sgn);
    case (size)
      2'd0:    return {{24{sgn & raw[7]}}, raw[7:0]};
      2'd1:    return {{16{sgn & raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  assign n_cur = nbytes(size_q);
  assign rd_k  = 2'(cnt_q - 3'd1);   // byte arriving this cycle was addressed last cycle
  assign wr_nk = 2'(cnt_q + 3'd1);

  // Round-robin search starting one past the last granted channel
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!grant_vld && in_req_ce[(int'(ptr_q) + i) % NUM_CH]) begin
        grant_vld = 1'b1;
        grant     = PW'((int'(ptr_q) + i) % NUM_CH);
      end
    end
  end

  // Fields of the granted channel and the read buffer with the incoming byte merged in
  always_comb begin
    g_addr   = in_req_addr[32*int'(grant) +: 32];
    g_dat    = in_req_data[32*int'(grant) +: 32];
    g_size   = in_req_size[2*int'(grant) +: 2];
    g_wr     = in_req_wr[grant];
    g_sgn    = in_req_signed[grant];
    g_io     = (g_addr[17:16] == 2'b11);
    rbuf_ins = rbuf_q;
    rbuf_ins[8*rd_k +: 8] = in_ram_data;
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_n    = state_q;
    ptr_n      = ptr_q;
    ch_n       = ch_q;
    addr_n     = addr_q;
    wdat_n     = wdat_q;
    rbuf_n     = rbuf_q;
    size_n     = size_q;
    sgn_n      = sgn_q;
    io_n       = io_q;
    cnt_n      = cnt_q;
    gap_n      = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
    ram_rw_n   = out_ram_rw;
    ram_addr_n = out_ram_address;
    ram_dat_n  = out_ram_data;
    data_n     = out_data;
    done_n     = '0;
    case (state_q)
      S_IDLE: begin
        if (!in_misbranch && grant_vld) begin
          ptr_n  = grant;
          ch_n   = grant;
          addr_n = g_addr;
          wdat_n = g_dat;
          size_n = g_size;
          sgn_n  = g_sgn;
          io_n   = g_io;
          cnt_n  = 3'd0;
          rbuf_n = '0;
          if (!g_wr) begin
            state_n    = S_READ;
            ram_rw_n   = 1'b0;
            ram_addr_n = g_addr;
          end else if (g_io && (in_uart_full || gap_q != '0)) begin
            state_n = S_IO_WAIT;
          end else begin
            state_n    = S_WRITE;
            ram_rw_n   = 1'b1;
            ram_addr_n = g_addr;
            ram_dat_n  = g_dat[7:0];
          end
        end
      end
      S_IO_WAIT: begin
        if (!in_uart_full && gap_q == '0) begin
          state_n    = S_WRITE;
          ram_rw_n   = 1'b1;
          ram_addr_n = addr_q;
          ram_dat_n  = wdat_q[7:0];
          cnt_n      = 3'd0;
        end
      end
      S_WRITE: begin
        // cnt_q is the index of the byte currently on the bus
        if (cnt_q == n_cur - 3'd1) begin
          state_n      = S_DONE;
          ram_rw_n     = 1'b0;
          done_n[ch_q] = 1'b1;
          if (io_q) gap_n = GW'(IO_GAP);
        end else begin
          cnt_n      = cnt_q + 3'd1;
          ram_addr_n = addr_q + 32'(wr_nk);
          ram_dat_n  = wdat_q[8*wr_nk +: 8];
        end
      end
      S_READ: begin
        // cnt_q counts bus cycles; byte cnt_q-1 arrives while address cnt_q is shown
        if (in_misbranch && FLUSH_MASK[ch_q]) begin
          state_n = S_IDLE;
        end else begin
          if (cnt_q != 3'd0) rbuf_n = rbuf_ins;
          if (cnt_q == n_cur) begin
            state_n      = S_DONE;
            done_n[ch_q] = 1'b1;
            data_n       = extend(rbuf_ins, size_q, sgn_q);
          end else begin
            cnt_n = cnt_q + 3'd1;
            if ((cnt_q + 3'd1) < n_cur) ram_addr_n = addr_q + 32'(cnt_q) + 32'd1;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers; rdy low holds everything in place
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      ptr_q           <= PW'(NUM_CH - 1);
      ch_q            <= '0;
      addr_q          <= '0;
      wdat_q          <= '0;
      rbuf_q          <= '0;
      size_q          <= '0;
      sgn_q           <= 1'b0;
      io_q            <= 1'b0;
      cnt_q           <= '0;
      gap_q           <= '0;
      out_ram_rw      <= 1'b0;
      out_ram_address <= '0;
      out_ram_data    <= '0;
      out_done        <= '0;
      out_data        <= '0;
    end else if (rdy) begin
      state_q         <= state_n;
      ptr_q           <= ptr_n;
      ch_q            <= ch_n;
      addr_q          <= addr_n;
      wdat_q          <= wdat_n;
      rbuf_q          <= rbuf_n;
      size_q          <= size_n;
      sgn_q           <= sgn_n;
      io_q            <= io_n;
      cnt_q           <= cnt_n;
      gap_q           <= gap_n;
      out_ram_rw      <= ram_rw_n;
      out_ram_address <= ram_addr_n;
      out_ram_data    <= ram_dat_n;
      out_done        <= done_n;
      out_data        <= data_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: byte RAM model, done-event scoreboard, one task per scenario.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// The RAM read port advances only in cycles where rdy is high.
module tb_mem_arbiter_rr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic [2:0]  in_req_ce = '0, in_req_wr = '0, in_req_signed = '0;
  logic [5:0]  in_req_size = '0;
  logic [95:0] in_req_addr = '0, in_req_data = '0;
  logic        in_misbranch = 1'b0, in_uart_full = 1'b0;
  logic [7:0]  in_ram_data = '0;
  logic        out_ram_rw;
  logic [31:0] out_ram_address, out_data;
  logic [7:0]  out_ram_data;
  logic [2:0]  out_done;

  typedef struct { int cyc; logic [2:0] done; logic [31:0] data; bit chk; } exp_t;
  typedef struct { int cyc; logic [2:0] done; logic [31:0] data; } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int   io_log[$];
  logic [7:0] mem [logic [31:0]];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  mem_arbiter_rr dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_req_ce(in_req_ce), .in_req_wr(in_req_wr), .in_req_size(in_req_size),
    .in_req_signed(in_req_signed), .in_req_addr(in_req_addr), .in_req_data(in_req_data),
    .in_misbranch(in_misbranch), .in_uart_full(in_uart_full), .in_ram_data(in_ram_data),
    .out_ram_rw(out_ram_rw), .out_ram_address(out_ram_address), .out_ram_data(out_ram_data),
    .out_done(out_done), .out_data(out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM: one-cycle read latency, write on the edge ending a rw=1 cycle
  always @(posedge clk) begin
    if (rdy) begin
      if (out_ram_rw === 1'b1) mem[out_ram_address] = out_ram_data;
      in_ram_data <= mem.exists(out_ram_address) ? mem[out_ram_address] : 8'h00;
    end
  end

  // Done and IO-write monitors
  always @(negedge clk) begin
    if (out_done !== 3'b000 && !rst) obs_q.push_back('{cyc: cyc, done: out_done, data: out_data});
    if (out_ram_rw === 1'b1 && out_ram_address[17:16] == 2'b11) io_log.push_back(cyc);
  end

  task automatic set_req(input int ch, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
    in_req_wr[ch] = wr;
    in_req_size[2*ch +: 2] = sz;
    in_req_signed[ch] = sg;
    in_req_addr[32*ch +: 32] = a;
    in_req_data[32*ch +: 32] = d;
  endtask

  task automatic push_exp(input int c, input int ch, input logic [31:0] d, input bit chk);
    exp_q.push_back('{cyc: c, done: 3'b001 << ch, data: d, chk: chk});
  endtask

  // Waits for the next done event; a timeout yields cyc=-1
  task automatic wait_obs(input int budget, output obs_t o);
    int i = 0;
    o = '{cyc: -1, done: 3'b000, data: 32'h0};
    while (obs_q.size() == 0 && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    if (obs_q.size() != 0) o = obs_q.pop_front();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (out_ram_rw !== 1'b0) begin bad++; $display("FAIL reset_rw got %b want 0", out_ram_rw); end
    total++; if (out_ram_address !== 32'h0 || out_ram_data !== 8'h0) begin
      bad++; $display("FAIL reset_bus got addr=%h data=%h want 0/0", out_ram_address, out_ram_data); end
    total++; if (out_done !== 3'b000 || out_data !== 32'h0) begin
      bad++; $display("FAIL reset_done got done=%b data=%h want 000/0", out_done, out_data); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_read4();
    int T; obs_t o; exp_t e;
    tick(); T = cyc;
    set_req(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    in_req_ce[1] = 1'b1;
    push_exp(T + 6, 1, 32'h12345678, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (out_ram_address !== 32'h100 + 32'(k) || out_ram_rw !== 1'b0) begin
        bad++; $display("FAIL read4_addr%0d got addr=%h rw=%b want %h rw=0", k, out_ram_address, out_ram_rw, 32'h100 + 32'(k));
      end
    end
    wait_obs(20, o); e = exp_q.pop_front(); in_req_ce[1] = 1'b0;
    total++;
    if (o.done !== e.done || o.cyc != e.cyc || (e.chk && o.data !== e.data)) begin
      bad++; $display("FAIL read4_done got done=%b cyc=%0d data=%h want done=%b cyc=%0d data=%h", o.done, o.cyc, o.data, e.done, e.cyc, e.data);
    end
  endtask

  task automatic test_extend();
    logic [1:0]  sz [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        sg [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad [4] = '{32'h10, 32'h10, 32'h20, 32'h20};
    logic [31:0] ex [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
    int T; obs_t o; exp_t e;
    for (int i = 0; i < 4; i++) begin
      tick(); T = cyc;
      set_req(0, 1'b0, sz[i], sg[i], ad[i], 32'h0);
      in_req_ce[0] = 1'b1;
      push_exp(T + ((sz[i] == 2'd0) ? 1 : 2) + 2, 0, ex[i], 1'b1);
      wait_obs(20, o); e = exp_q.pop_front(); in_req_ce[0] = 1'b0;
      total++;
      if (o.done !== e.done || o.cyc != e.cyc || o.data !== e.data) begin
        bad++; $display("FAIL extend%0d got done=%b cyc=%0d data=%h want done=%b cyc=%0d data=%h", i, o.done, o.cyc, o.data, e.done, e.cyc, e.data);
      end
    end
  endtask

  task automatic test_rr();
    int chs [4] = '{0, 1, 2, 0};
    logic [31:0] dat [4] = '{32'h78, 32'h56, 32'h34, 32'h78};
    int T; obs_t o; exp_t e;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; T = cyc;
    for (int c = 0; c < 3; c++) set_req(c, 1'b0, 2'd0, 1'b0, 32'h100 + 32'(c), 32'h0);
    in_req_ce = 3'b111;
    for (int i = 0; i < 4; i++) push_exp(T + 3 + 4*i, chs[i], dat[i], 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_obs(20, o); e = exp_q.pop_front();
      in_req_ce[chs[i]] = 1'b0;
      total++;
      if (o.done !== e.done || o.cyc != e.cyc || o.data !== e.data) begin
        bad++; $display("FAIL rr_grant%0d got done=%b cyc=%0d data=%h want done=%b cyc=%0d data=%h", i, o.done, o.cyc, o.data, e.done, e.cyc, e.data);
      end
      if (i < 3) begin tick(); in_req_ce[chs[i]] = 1'b1; end
    end
    in_req_ce = 3'b000;
  endtask

  task automatic test_misbranch();
    int T; obs_t o; exp_t e;
    // flushable read aborted; a fresh grant in the next cycle proves IDLE
    tick(); T = cyc;
    set_req(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    in_req_ce[0] = 1'b1;
    repeat (3) tick();
    in_misbranch = 1'b1; in_req_ce[0] = 1'b0;
    tick();
    in_misbranch = 1'b0;
    set_req(1, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0);
    in_req_ce[1] = 1'b1;
    push_exp(T + 7, 1, 32'h56, 1'b1);
    @(negedge clk);
    total++; if (out_ram_rw !== 1'b0) begin bad++; $display("FAIL mis_abort_rw got %b want 0", out_ram_rw); end
    // unflushable channel read, write, grant-cycle misbranch, done-cycle misbranch
    wait_obs(20, o); e = exp_q.pop_front(); in_req_ce[1] = 1'b0;
    total++;
    if (o.done !== e.done || o.cyc != e.cyc || o.data !== e.data) begin
      bad++; $display("FAIL mis_abort got done=%b cyc=%0d data=%h want done=%b cyc=%0d data=%h", o.done, o.cyc, o.data, e.done, e.cyc, e.data);
    end
    tick(); T = cyc;
    set_req(2, 1'b0, 2'd0, 1'b0, 32'h102, 32'h0);
    in_req_ce[2] = 1'b1;
    push_exp(T + 3, 2, 32'h34, 1'b1);
    tick(); in_misbranch = 1'b1;
    tick(); in_misbranch = 1'b0;
    wait_obs(20, o); e = exp_q.pop_front(); in_req_ce[2] = 1'b0;
    total++;
    if (o.done !== e.done || o.cyc != e.cyc || o.data !== e.data) begin
      bad++; $display("FAIL mis_noflush got done=%b cyc=%0d data=%h want done=%b cyc=%0d data=%h", o.done, o.cyc, o.data, e.done, e.cyc, e.data);
    end
    tick(); T = cyc;
    set_req(2, 1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFEF00D);
    in_req_ce[2] = 1'b1;
    push_exp(T + 5, 2, 32'h0, 1'b0);
    repeat (2) tick();
    in_misbranch = 1'b1;
    tick(); in_misbranch = 1'b0;
    wait_obs(20, o); e = exp_q.pop_front(); in_req_ce[2] = 1'b0;
    total++;
    if (o.done !== e.done || o.cyc != e.cyc) begin
      bad++; $display("FAIL mis_write got done=%b cyc=%0d want done=%b cyc=%0d", o.done, o.cyc, e.done, e.cyc);
    end
    total++;
    if ({mem[32'h303], mem[32'h302], mem[32'h301], mem[32'h300]} !== 32'hCAFEF00D) begin
      bad++; $display("FAIL mis_write_mem got %h want cafef00d", {mem[32'h303], mem[32'h302], mem[32'h301], mem[32'h300]});
    end
    tick(); T = cyc;
    set_req(1, 1'b0, 2'd0, 1'b0, 32'h100, 32'h0);
    in_req_ce[1] = 1'b1; in_misbranch = 1'b1;
    push_exp(T + 4, 1, 32'h78, 1'b1);
    tick(); in_misbranch = 1'b0;
    wait_obs(20, o); e = exp_q.pop_front(); in_req_ce[1] = 1'b0;
    total++;
    if (o.done !== e.done || o.cyc != e.cyc || o.data !== e.data) begin
      bad++; $display("FAIL mis_grant got done=%b cyc=%0d data=%h want done=%b cyc=%0d data=%h", o.done, o.cyc, o.data, e.done, e.cyc, e.data);
    end
    tick(); T = cyc;
    set_req(0, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0);
    in_req_ce[0] = 1'b1;
    push_exp(T + 3, 0, 32'h56, 1'b1);
    repeat (3) tick();
    in_misbranch = 1'b1;
    wait_obs(20, o); e = exp_q.pop_front(); in_req_ce[0] = 1'b0;
    tick(); in_misbranch = 1'b0;
    total++;
    if (o.done !== e.done || o.cyc != e.cyc || o.data !== e.data) begin
      bad++; $display("FAIL mis_done got done=%b cyc=%0d data=%h want done=%b cyc=%0d data=%h", o.done, o.cyc, o.data, e.done, e.cyc, e.data);
    end
  endtask

  task automatic test_io();
    int T; obs_t o; exp_t e;
    io_log.delete();
    in_uart_full = 1'b1;
    tick(); T = cyc;
    set_req(2, 1'b1, 2'd0, 1'b0, 32'h30000, 32'h41);
    in_req_ce[2] = 1'b1;
    push_exp(T + 7, 2, 32'h0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      if (c == 5) in_uart_full = 1'b0;
      @(negedge clk);
      total++; if (out_ram_rw !== 1'b0) begin bad++; $display("FAIL io_hold%0d got rw=%b want 0", c, out_ram_rw); end
      tick();
    end
    @(negedge clk);
    total++;
    if (out_ram_rw !== 1'b1 || out_ram_address !== 32'h30000 || out_ram_data !== 8'h41) begin
      bad++; $display("FAIL io_issue got rw=%b addr=%h data=%h want 1/00030000/41", out_ram_rw, out_ram_address, out_ram_data);
    end
    wait_obs(20, o); e = exp_q.pop_front(); in_req_ce[2] = 1'b0;
    total++;
    if (o.done !== e.done || o.cyc != e.cyc) begin
      bad++; $display("FAIL io_done got done=%b cyc=%0d want done=%b cyc=%0d", o.done, o.cyc, e.done, e.cyc);
    end
    // second IO write right behind the first: one extra IO_WAIT cycle for the gap
    tick(); T = cyc;
    set_req(2, 1'b1, 2'd0, 1'b0, 32'h30001, 32'h42);
    in_req_ce[2] = 1'b1;
    push_exp(T + 3, 2, 32'h0, 1'b0);
    wait_obs(20, o); e = exp_q.pop_front(); in_req_ce[2] = 1'b0;
    total++;
    if (o.done !== e.done || o.cyc != e.cyc) begin
      bad++; $display("FAIL io_gap_done got done=%b cyc=%0d want done=%b cyc=%0d", o.done, o.cyc, e.done, e.cyc);
    end
    total++;
    if (io_log.size() != 2 || io_log[1] - io_log[0] != 4) begin
      bad++; $display("FAIL io_gap got %0d io bytes, spacing %0d, want 2 bytes spacing 4", io_log.size(), (io_log.size() == 2) ? io_log[1] - io_log[0] : -1);
    end
    // IO reads ignore uart_full
    in_uart_full = 1'b1;
    tick(); T = cyc;
    set_req(0, 1'b0, 2'd0, 1'b0, 32'h30010, 32'h0);
    in_req_ce[0] = 1'b1;
    push_exp(T + 3, 0, 32'h5A, 1'b1);
    wait_obs(20, o); e = exp_q.pop_front(); in_req_ce[0] = 1'b0;
    in_uart_full = 1'b0;
    total++;
    if (o.done !== e.done || o.cyc != e.cyc || o.data !== e.data) begin
      bad++; $display("FAIL io_read got done=%b cyc=%0d data=%h want done=%b cyc=%0d data=%h", o.done, o.cyc, o.data, e.done, e.cyc, e.data);
    end
  endtask

  task automatic test_rdy();
    logic [31:0] exp_addr [8] = '{32'h0, 32'h200, 32'h201, 32'h202, 32'h202, 32'h202, 32'h202, 32'h203};
    int T; obs_t o; exp_t e;
    tick(); T = cyc;
    set_req(0, 1'b1, 2'd2, 1'b0, 32'h200, 32'hDEADBEEF);
    in_req_ce[0] = 1'b1;
    push_exp(T + 5, 0, 32'h0, 1'b0);
    wait_obs(20, o); e = exp_q.pop_front(); in_req_ce[0] = 1'b0;
    total++;
    if (o.done !== e.done || o.cyc != e.cyc) begin
      bad++; $display("FAIL rdy_write got done=%b cyc=%0d want done=%b cyc=%0d", o.done, o.cyc, e.done, e.cyc);
    end
    total++;
    if ({mem[32'h203], mem[32'h202], mem[32'h201], mem[32'h200]} !== 32'hDEADBEEF) begin
      bad++; $display("FAIL rdy_write_mem got %h want deadbeef", {mem[32'h203], mem[32'h202], mem[32'h201], mem[32'h200]});
    end
    tick(); T = cyc;
    set_req(0, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
    in_req_ce[0] = 1'b1;
    push_exp(T + 9, 0, 32'hDEADBEEF, 1'b1);
    for (int c = 1; c < 8; c++) begin
      tick();
      if (c == 3) rdy = 1'b0;
      if (c == 6) rdy = 1'b1;
      @(negedge clk);
      total++;
      if (out_ram_address !== exp_addr[c] || out_ram_rw !== 1'b0) begin
        bad++; $display("FAIL rdy_bus%0d got addr=%h rw=%b want %h rw=0", c, out_ram_address, out_ram_rw, exp_addr[c]);
      end
    end
    wait_obs(20, o); e = exp_q.pop_front(); in_req_ce[0] = 1'b0;
    total++;
    if (o.done !== e.done || o.cyc != e.cyc || o.data !== e.data) begin
      bad++; $display("FAIL rdy_read got done=%b cyc=%0d data=%h want done=%b cyc=%0d data=%h", o.done, o.cyc, o.data, e.done, e.cyc, e.data);
    end
  endtask

  task automatic test_reset_mid();
    int T; obs_t o; exp_t e;
    tick();
    set_req(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    in_req_ce[1] = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick(); rst = 1'b0; in_req_ce[1] = 1'b0;
    @(negedge clk);
    total++;
    if (out_ram_address !== 32'h0 || out_ram_rw !== 1'b0 || out_done !== 3'b000) begin
      bad++; $display("FAIL rst_mid got addr=%h rw=%b done=%b want 0/0/000", out_ram_address, out_ram_rw, out_done);
    end
    tick(); T = cyc;
    set_req(0, 1'b0, 2'd0, 1'b0, 32'h100, 32'h0);
    set_req(2, 1'b0, 2'd0, 1'b0, 32'h102, 32'h0);
    in_req_ce = 3'b101;
    push_exp(T + 3, 0, 32'h78, 1'b1);
    push_exp(T + 7, 2, 32'h34, 1'b1);
    for (int i = 0; i < 2; i++) begin
      wait_obs(20, o); e = exp_q.pop_front();
      in_req_ce[(i == 0) ? 0 : 2] = 1'b0;
      total++;
      if (o.done !== e.done || o.cyc != e.cyc || o.data !== e.data) begin
        bad++; $display("FAIL rst_mid_grant%0d got done=%b cyc=%0d data=%h want done=%b cyc=%0d data=%h", i, o.done, o.cyc, o.data, e.done, e.cyc, e.data);
      end
    end
    repeat (8) tick();
  endtask

  initial begin
    mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
    mem[32'h10]  = 8'h80; mem[32'h20]  = 8'h01; mem[32'h21]  = 8'h80;
    mem[32'h30010] = 8'h5A;
    test_reset();
    test_read4();
    test_extend();
    test_rr();
    test_misbranch();
    test_io();
    test_rdy();
    test_reset_mid();
    total++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      bad++; $display("FAIL leftover got %0d unexpected done events, %0d missing, want 0/0", obs_q.size(), exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish by 200us want finish");
    $fatal(1);
  end

endmodule
